// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station: default widths,
// the dispatch payload layout, and a packed view of one payload.
package rs_pkg;

    localparam int XLEN_D   = 32;
    localparam int TAG_W_D  = 5;
    localparam int OP_W_D   = 5;

    // Payload width as a function of the field widths; dispatch uses the same formula.
    function automatic int rs_data_w(int xlen, int tag_w, int op_w);
        return op_w + tag_w + 2 * (1 + xlen);
    endfunction

    localparam int DATA_W_D = rs_data_w(XLEN_D, TAG_W_D, OP_W_D);

    // Field offsets for the default configuration, LSB positions.
    localparam int S2_LSB     = 0;
    localparam int S2_RDY_BIT = XLEN_D;
    localparam int S1_LSB     = XLEN_D + 1;
    localparam int S1_RDY_BIT = 2 * XLEN_D + 1;
    localparam int DEST_LSB   = 2 * XLEN_D + 2;
    localparam int OP_LSB     = DEST_LSB + TAG_W_D;

    // Payload, MSB first. A source that is not ready carries its waiting tag in the low bits.
    typedef struct packed {
        logic [OP_W_D-1:0]  op;
        logic [TAG_W_D-1:0] dest;
        logic               s1_rdy;
        logic [XLEN_D-1:0]  s1;
        logic               s2_rdy;
        logic [XLEN_D-1:0]  s2;
    } rs_payload_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds a micro-op and its two operands,
// captures operands from the CDB at write time or later by tag match.
module rs_entry
    import rs_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int TAG_W  = TAG_W_D,
    parameter int OP_W   = OP_W_D,
    parameter int DATA_W = rs_data_w(XLEN, TAG_W, OP_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_value,
    input  logic              clr,
    output logic              busy,
    output logic              eligible,
    output logic [OP_W-1:0]   op,
    output logic [TAG_W-1:0]  dest,
    output logic [XLEN-1:0]   src1,
    output logic [XLEN-1:0]   src2
);

    localparam int L_S2_LSB   = 0;
    localparam int L_S2_RDY   = XLEN;
    localparam int L_S1_LSB   = XLEN + 1;
    localparam int L_S1_RDY   = 2 * XLEN + 1;
    localparam int L_DEST_LSB = 2 * XLEN + 2;
    localparam int L_OP_LSB   = L_DEST_LSB + TAG_W;

    logic              s1_rdy;
    logic              s2_rdy;
    logic [OP_W-1:0]   w_op;
    logic [TAG_W-1:0]  w_dest;
    logic              w_s1_rdy;
    logic              w_s2_rdy;
    logic [XLEN-1:0]   w_s1;
    logic [XLEN-1:0]   w_s2;
    logic              w_s1_hit;
    logic              w_s2_hit;
    logic              s1_hit;
    logic              s2_hit;

    assign w_op     = wr_data[L_OP_LSB +: OP_W];
    assign w_dest   = wr_data[L_DEST_LSB +: TAG_W];
    assign w_s1_rdy = wr_data[L_S1_RDY];
    assign w_s1     = wr_data[L_S1_LSB +: XLEN];
    assign w_s2_rdy = wr_data[L_S2_RDY];
    assign w_s2     = wr_data[L_S2_LSB +: XLEN];

    // Only the low TAG_W bits of a waiting operand are a tag; the rest are ignored.
    assign w_s1_hit = cdb_valid && !w_s1_rdy && (cdb_tag == w_s1[TAG_W-1:0]);
    assign w_s2_hit = cdb_valid && !w_s2_rdy && (cdb_tag == w_s2[TAG_W-1:0]);
    assign s1_hit   = cdb_valid && !s1_rdy && (cdb_tag == src1[TAG_W-1:0]);
    assign s2_hit   = cdb_valid && !s2_rdy && (cdb_tag == src2[TAG_W-1:0]);

    assign eligible = busy & s1_rdy & s2_rdy;

    // Slot state: reset/flush, then issue-clear, then write into a free slot, then wakeup.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy   <= 1'b0;
            s1_rdy <= 1'b0;
            s2_rdy <= 1'b0;
            op     <= '0;
            dest   <= '0;
            src1   <= '0;
            src2   <= '0;
        end else if (clr) begin
            busy <= 1'b0;
        end else if (wr_en && !busy) begin
            busy   <= 1'b1;
            op     <= w_op;
            dest   <= w_dest;
            s1_rdy <= w_s1_rdy | w_s1_hit;
            src1   <= w_s1_hit ? cdb_value : w_s1;
            s2_rdy <= w_s2_rdy | w_s2_hit;
            src2   <= w_s2_hit ? cdb_value : w_s2;
        end else if (busy) begin
            if (s1_hit) begin
                s1_rdy <= 1'b1;
                src1   <= cdb_value;
            end
            if (s2_hit) begin
                s2_rdy <= 1'b1;
                src2   <= cdb_value;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Two-entry reservation station: two slots, an age bit, and an
// oldest-ready select feeding the functional unit through valid/ready.
module rs_station
    import rs_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int TAG_W  = TAG_W_D,
    parameter int OP_W   = OP_W_D,
    parameter int DATA_W = rs_data_w(XLEN, TAG_W, OP_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_0_data,
    input  logic              in_0_valid,
    input  logic [DATA_W-1:0] in_1_data,
    input  logic              in_1_valid,
    output logic              empty_0,
    output logic              empty_1,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_value,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [TAG_W-1:0]  issue_dest,
    output logic [XLEN-1:0]   issue_src1,
    output logic [XLEN-1:0]   issue_src2
);

    logic              busy_0, busy_1;
    logic              elig_0, elig_1;
    logic [OP_W-1:0]   op_0, op_1;
    logic [TAG_W-1:0]  dest_0, dest_1;
    logic [XLEN-1:0]   src1_0, src1_1, src2_0, src2_1;
    logic              old1;
    logic              sel1;
    logic              fire;
    logic              wr_0, wr_1;

    assign empty_0 = ~busy_0;
    assign empty_1 = ~busy_1;
    assign wr_0    = in_0_valid & ~busy_0;
    assign wr_1    = in_1_valid & ~busy_1;

    // Slot 1 wins only if it is the sole eligible slot or the older of two.
    assign sel1        = elig_1 & (~elig_0 | old1);
    assign issue_valid = elig_0 | elig_1;
    assign fire        = issue_valid & issue_ready;

    rs_entry #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)) u_entry_0 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(in_0_valid), .wr_data(in_0_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .clr(fire & ~sel1),
        .busy(busy_0), .eligible(elig_0),
        .op(op_0), .dest(dest_0), .src1(src1_0), .src2(src2_0)
    );

    rs_entry #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)) u_entry_1 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(in_1_valid), .wr_data(in_1_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .clr(fire & sel1),
        .busy(busy_1), .eligible(elig_1),
        .op(op_1), .dest(dest_1), .src1(src1_1), .src2(src2_1)
    );

    // Age bit: a lone write makes the other (busy) slot older; a double write makes slot 0 older.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            old1 <= 1'b0;
        end else if (wr_0 && wr_1) begin
            old1 <= 1'b0;
        end else if (wr_0) begin
            old1 <= busy_1;
        end else if (wr_1) begin
            old1 <= ~busy_0;
        end
    end

    // Issue mux; outputs are forced to zero while nothing is eligible.
    always_comb begin
        issue_op   = '0;
        issue_dest = '0;
        issue_src1 = '0;
        issue_src2 = '0;
        if (issue_valid) begin
            issue_op   = sel1 ? op_1   : op_0;
            issue_dest = sel1 ? dest_1 : dest_0;
            issue_src1 = sel1 ? src1_1 : src1_0;
            issue_src2 = sel1 ? src2_1 : src2_0;
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus a randomized
// run compared against a slot/sequence-number reference model.
module tb_rs_station;
    import rs_pkg::*;

    localparam int XLEN = 32;
    localparam int TAG_W = 5;
    localparam int OP_W = 5;
    localparam int DATA_W = 76;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [DATA_W-1:0] in_0_data, in_1_data;
    logic              in_0_valid, in_1_valid;
    logic              empty_0, empty_1;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_value;
    logic              issue_valid, issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_dest;
    logic [XLEN-1:0]   issue_src1, issue_src2;

    int errors = 0;
    int checks = 0;

    rs_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_0_data(in_0_data), .in_0_valid(in_0_valid),
        .in_1_data(in_1_data), .in_1_valid(in_1_valid),
        .empty_0(empty_0), .empty_1(empty_1),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_src1(issue_src1), .issue_src2(issue_src2)
    );

    always #5 clk = ~clk;

    // Reference model: each slot remembers when it was written; oldest ready wins.
    bit              m_busy[2];
    logic [OP_W-1:0] m_op[2];
    logic [TAG_W-1:0] m_dest[2];
    bit              m_r1[2], m_r2[2];
    logic [XLEN-1:0] m_v1[2], m_v2[2];
    int              m_seq[2];
    int              seq_ctr = 0;

    function automatic logic [DATA_W-1:0] mk(input logic [4:0] op, input logic [4:0] dest,
                                             input bit r1, input logic [31:0] v1,
                                             input bit r2, input logic [31:0] v2);
        rs_payload_t p;
        p.op = op; p.dest = dest; p.s1_rdy = r1; p.s1 = v1; p.s2_rdy = r2; p.s2 = v2;
        return p;
    endfunction

    function automatic void model_select(output bit v, output int s);
        bit e0, e1;
        e0 = m_busy[0] && m_r1[0] && m_r2[0];
        e1 = m_busy[1] && m_r1[1] && m_r2[1];
        v = e0 || e1;
        if (e0 && e1) s = (m_seq[0] < m_seq[1]) ? 0 : 1;
        else s = e1 ? 1 : 0;
    endfunction

    function automatic void model_step();
        bit v, iss, b_pre[2], inv[2];
        int s;
        rs_payload_t p;
        logic [DATA_W-1:0] d[2];
        if (rst || flush) begin
            m_busy[0] = 0; m_busy[1] = 0;
            return;
        end
        model_select(v, s);
        iss = v && issue_ready;
        inv[0] = in_0_valid; inv[1] = in_1_valid;
        d[0] = in_0_data; d[1] = in_1_data;
        b_pre = m_busy;
        for (int i = 0; i < 2; i++) begin
            if (iss && s == i) begin
                m_busy[i] = 0;
            end else if (inv[i] && !b_pre[i]) begin
                p = d[i];
                m_busy[i] = 1; m_op[i] = p.op; m_dest[i] = p.dest;
                m_r1[i] = p.s1_rdy; m_v1[i] = p.s1;
                m_r2[i] = p.s2_rdy; m_v2[i] = p.s2;
                if (!m_r1[i] && cdb_valid && cdb_tag == p.s1[4:0]) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
                if (!m_r2[i] && cdb_valid && cdb_tag == p.s2[4:0]) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
                m_seq[i] = seq_ctr; seq_ctr++;
            end else if (b_pre[i]) begin
                if (!m_r1[i] && cdb_valid && cdb_tag == m_v1[i][4:0]) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
                if (!m_r2[i] && cdb_valid && cdb_tag == m_v2[i][4:0]) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; in_0_valid = 0; in_1_valid = 0;
        cdb_valid = 0; issue_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_0_data = '0; in_1_data = '0; cdb_tag = '0; cdb_value = '0;
        rst = 1;
        tick(); tick();
        rst = 0;
        checks++; if (empty_0 !== 1'b1 || empty_1 !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b%0b exp=11", empty_0, empty_1); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", issue_valid); end
        checks++; if ({issue_op, issue_dest, issue_src1, issue_src2} !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {issue_op, issue_dest, issue_src1, issue_src2}); end
    endtask

    task automatic test_basic_issue();
        in_0_data = mk(3, 7, 1, 5, 1, 9); in_0_valid = 1;
        tick();
        in_0_valid = 0;
        checks++; if (empty_0 !== 1'b0 || issue_valid !== 1'b1) begin errors++; $display("FAIL basic_state got empty0=%0b valid=%0b exp empty0=0 valid=1", empty_0, issue_valid); end
        checks++; if (issue_op !== 5'd3 || issue_dest !== 5'd7 || issue_src1 !== 32'd5 || issue_src2 !== 32'd9)
            begin errors++; $display("FAIL basic_fields got op=%0d dest=%0d s1=%0d s2=%0d exp 3 7 5 9", issue_op, issue_dest, issue_src1, issue_src2); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++; if (empty_0 !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got empty0=%0b valid=%0b exp 1 0", empty_0, issue_valid); end
    endtask

    task automatic test_wakeup();
        in_1_data = mk(1, 2, 1, 32'h11, 0, 32'hABCD_0000 | 32'd12); in_1_valid = 1;
        tick();
        in_1_valid = 0;
        checks++; if (empty_1 !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got empty1=%0b valid=%0b exp 0 0", empty_1, issue_valid); end
        cdb_valid = 1; cdb_tag = 13; cdb_value = 32'hBEEF;
        tick();
        cdb_valid = 0;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag got valid=%0b exp 0", issue_valid); end
        cdb_valid = 1; cdb_tag = 12; cdb_value = 32'hDEAD;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass got valid=%0b exp 0", issue_valid); end
        tick();
        cdb_valid = 0;
        checks++; if (issue_valid !== 1'b1 || issue_src2 !== 32'hDEAD || issue_src1 !== 32'h11 || issue_dest !== 5'd2)
            begin errors++; $display("FAIL wake_issue got valid=%0b s1=%h s2=%h dest=%0d exp 1 11 dead 2", issue_valid, issue_src1, issue_src2, issue_dest); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++; if (empty_1 !== 1'b1) begin errors++; $display("FAIL wake_drain got empty1=%0b exp 1", empty_1); end
    endtask

    task automatic test_write_capture();
        in_0_data = mk(4, 6, 0, 32'hFFFF_FF04, 1, 32'h22); in_0_valid = 1;
        cdb_valid = 1; cdb_tag = 4; cdb_value = 32'h55;
        tick();
        in_0_valid = 0; cdb_valid = 0;
        checks++; if (issue_valid !== 1'b1 || issue_src1 !== 32'h55 || issue_src2 !== 32'h22)
            begin errors++; $display("FAIL capture got valid=%0b s1=%h s2=%h exp 1 55 22", issue_valid, issue_src1, issue_src2); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
    endtask

    task automatic test_stall_order();
        in_0_data = mk(10, 20, 1, 32'hA0, 1, 32'hA1); in_0_valid = 1;
        in_1_data = mk(11, 21, 1, 32'hB0, 1, 32'hB1); in_1_valid = 1;
        tick();
        in_0_valid = 0; in_1_valid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (issue_valid !== 1'b1 || issue_op !== 5'd10 || issue_dest !== 5'd20 || issue_src1 !== 32'hA0 || issue_src2 !== 32'hA1)
                begin errors++; $display("FAIL stall_hold cyc=%0d got op=%0d dest=%0d s1=%h s2=%h exp 10 20 a0 a1", k, issue_op, issue_dest, issue_src1, issue_src2); end
            tick();
        end
        issue_ready = 1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_dest !== 5'd21 || issue_src1 !== 32'hB0 || empty_0 !== 1'b1)
            begin errors++; $display("FAIL stall_second got valid=%0b dest=%0d s1=%h empty0=%0b exp 1 21 b0 1", issue_valid, issue_dest, issue_src1, empty_0); end
        tick();
        issue_ready = 0;
        checks++; if (issue_valid !== 1'b0 || empty_1 !== 1'b1) begin errors++; $display("FAIL stall_drain got valid=%0b empty1=%0b exp 0 1", issue_valid, empty_1); end
    endtask

    task automatic test_age();
        in_1_data = mk(5, 15, 1, 32'h1, 1, 32'h2); in_1_valid = 1;
        tick();
        in_1_valid = 0;
        in_0_data = mk(6, 16, 1, 32'h3, 1, 32'h4); in_0_valid = 1;
        tick();
        in_0_valid = 0;
        checks++; if (issue_dest !== 5'd15) begin errors++; $display("FAIL age_first got dest=%0d exp 15", issue_dest); end
        issue_ready = 1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_dest !== 5'd16) begin errors++; $display("FAIL age_second got valid=%0b dest=%0d exp 1 16", issue_valid, issue_dest); end
        tick();
        issue_ready = 0;
    endtask

    task automatic test_flush();
        in_0_data = mk(7, 1, 0, 32'd20, 1, 32'h0); in_0_valid = 1;
        in_1_data = mk(8, 2, 1, 32'h0, 0, 32'd21); in_1_valid = 1;
        tick();
        in_0_valid = 0; in_1_valid = 0;
        flush = 1; cdb_valid = 1; cdb_tag = 20; cdb_value = 32'h1234;
        in_0_data = mk(9, 3, 1, 32'h5, 1, 32'h6); in_0_valid = 1;
        tick();
        flush = 0; cdb_valid = 0; in_0_valid = 0;
        checks++; if (empty_0 !== 1'b1 || empty_1 !== 1'b1 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL flush_clear got empty=%0b%0b valid=%0b exp 11 0", empty_0, empty_1, issue_valid); end
        // A write into a busy slot must be ignored.
        in_0_data = mk(6, 11, 1, 32'h77, 0, 32'd9); in_0_valid = 1;
        tick();
        in_0_data = mk(2, 3, 1, 32'h1, 1, 32'h2);
        tick();
        in_0_valid = 0;
        checks++; if (issue_valid !== 1'b0 || empty_0 !== 1'b0) begin errors++; $display("FAIL busy_write got valid=%0b empty0=%0b exp 0 0", issue_valid, empty_0); end
        cdb_valid = 1; cdb_tag = 9; cdb_value = 32'h99;
        tick();
        cdb_valid = 0;
        checks++; if (issue_valid !== 1'b1 || issue_op !== 5'd6 || issue_dest !== 5'd11 || issue_src1 !== 32'h77 || issue_src2 !== 32'h99)
            begin errors++; $display("FAIL busy_keep got op=%0d dest=%0d s1=%h s2=%h exp 6 11 77 99", issue_op, issue_dest, issue_src1, issue_src2); end
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_random();
        bit v;
        int s;
        logic [OP_W+TAG_W+2*XLEN-1:0] exp_out;
        for (int n = 0; n < 400; n++) begin
            in_0_valid  = ($urandom_range(0, 2) == 0);
            in_1_valid  = ($urandom_range(0, 2) == 0);
            in_0_data   = mk(5'($urandom), 5'($urandom), bit'($urandom_range(0, 1)), {$urandom_range(0, 255), 8'($urandom_range(0, 7))},
                             bit'($urandom_range(0, 1)), {$urandom_range(0, 255), 8'($urandom_range(0, 7))});
            in_1_data   = mk(5'($urandom), 5'($urandom), bit'($urandom_range(0, 1)), {$urandom_range(0, 255), 8'($urandom_range(0, 7))},
                             bit'($urandom_range(0, 1)), {$urandom_range(0, 255), 8'($urandom_range(0, 7))});
            cdb_valid   = ($urandom_range(0, 1) == 1);
            cdb_tag     = 5'($urandom_range(0, 7));
            cdb_value   = $urandom;
            issue_ready = ($urandom_range(0, 4) < 3);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            model_select(v, s);
            exp_out = v ? {m_op[s], m_dest[s], m_v1[s], m_v2[s]} : '0;
            checks++; if (empty_0 !== !m_busy[0] || empty_1 !== !m_busy[1])
                begin errors++; $display("FAIL rand_empty n=%0d got=%0b%0b exp=%0b%0b", n, empty_0, empty_1, !m_busy[0], !m_busy[1]); end
            checks++; if (issue_valid !== v) begin errors++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, issue_valid, v); end
            checks++; if ({issue_op, issue_dest, issue_src1, issue_src2} !== exp_out)
                begin errors++; $display("FAIL rand_issue n=%0d got=%h exp=%h", n, {issue_op, issue_dest, issue_src1, issue_src2}, exp_out); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_write_capture();
        test_stall_order();
        test_age();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
